// File: rtl/sev_seg_scan_if.sv
// sev_seg_scan_if: value/config inputs and scan outputs of the two-display scan driver
interface sev_seg_scan_if;
  logic [15:0] val0;
  logic [15:0] val1;
  logic        lz_en;
  logic [1:0]  bright;
  logic [3:0]  nib0;
  logic [3:0]  nib1;
  logic [3:0]  D0_AN;
  logic [3:0]  D1_AN;
  logic        frame;
  modport master (output val0, val1, lz_en, bright, input nib0, nib1, D0_AN, D1_AN, frame);
  modport slave (input val0, val1, lz_en, bright, output nib0, nib1, D0_AN, D1_AN, frame);
endinterface

// File: rtl/sev_seg_scan.sv
// sev_seg_scan: time-multiplexed anode scan for two 4-digit displays with blanking and dimming
module sev_seg_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input logic          CLK_100MHZ,
  input logic          RST,
  sev_seg_scan_if.slave bus
);
  localparam int CW = $clog2(REFRESH_DIV);
  localparam int Q = REFRESH_DIV / 4;
  logic [CW-1:0] div_cnt;
  logic [1:0]    idx;
  logic [15:0]   sh0, sh1;
  logic          cap, wrap, gate, blank0, blank1;
  logic [3:0]    an_on;
  // slot timing, brightness window and leading-zero detection from the current shadow
  always_comb begin
    cap = div_cnt == '0 && idx == 2'd0;
    wrap = div_cnt == CW'(REFRESH_DIV - 1);
    gate = 32'(div_cnt) < (32'(bus.bright) + 32'd1) * 32'(Q);
    blank0 = bus.lz_en && idx != 2'd0 && (sh0 >> {idx, 2'b00}) == 16'd0;
    blank1 = bus.lz_en && idx != 2'd0 && (sh1 >> {idx, 2'b00}) == 16'd0;
    an_on = ~(4'd1 << idx);
  end
  // counters, frame-start capture and registered outputs lagging the state by one cycle
  always_ff @(posedge CLK_100MHZ) begin
    if (RST) begin
      div_cnt <= '0;
      idx <= 2'd0;
      sh0 <= 16'd0;
      sh1 <= 16'd0;
      bus.nib0 <= 4'd0;
      bus.nib1 <= 4'd0;
      bus.D0_AN <= 4'hF;
      bus.D1_AN <= 4'hF;
      bus.frame <= 1'b0;
    end else begin
      div_cnt <= wrap ? '0 : div_cnt + CW'(1);
      idx <= wrap ? idx + 2'd1 : idx;
      sh0 <= cap ? bus.val0 : sh0;
      sh1 <= cap ? bus.val1 : sh1;
      bus.frame <= cap;
      bus.nib0 <= sh0[4*idx +: 4];
      bus.nib1 <= sh1[4*idx +: 4];
      bus.D0_AN <= gate && !blank0 ? an_on : 4'hF;
      bus.D1_AN <= gate && !blank1 ? an_on : 4'hF;
    end
  end
endmodule

// File: tb/tb_sev_seg_scan.sv
// tb_sev_seg_scan: directed scenario checks of the scan driver at REFRESH_DIV=8
module tb_sev_seg_scan;
  logic CLK_100MHZ = 1'b0;
  logic RST = 1'b1;
  int total = 0;
  int bad = 0;
  sev_seg_scan_if bus ();
  sev_seg_scan #(.REFRESH_DIV(8)) dut (.CLK_100MHZ(CLK_100MHZ), .RST(RST), .bus(bus));
  always #5 CLK_100MHZ = ~CLK_100MHZ;
  task automatic tick;
    @(posedge CLK_100MHZ);
    #1;
  endtask
  task automatic sync_frame;
    int n = 0;
    do begin
      tick();
      n++;
    end while (bus.frame !== 1'b1 && n < 100);
    total++;
    if (bus.frame !== 1'b1) begin
      bad++;
      $display("FAIL sync_frame: frame=%b after %0d cycles, want 1", bus.frame, n);
    end
  endtask
  task automatic test_reset;
    int pulses = 0;
    RST = 1'b1;
    bus.val0 = 16'h1234;
    bus.val1 = 16'hABCD;
    bus.lz_en = 1'b0;
    bus.bright = 2'd3;
    for (int i = 0; i < 3; i++) begin
      tick();
      total += 2;
      if (bus.D0_AN !== 4'hF) begin bad++; $display("FAIL reset_an: D0_AN=%b want 1111", bus.D0_AN); end
      if (bus.frame !== 1'b0) begin bad++; $display("FAIL reset_frame: frame=%b want 0", bus.frame); end
    end
    total++;
    if (bus.nib0 !== 4'd0) begin bad++; $display("FAIL reset_nib: nib0=%h want 0", bus.nib0); end
    RST = 1'b0;
    tick();
    total += 3;
    if (bus.D0_AN !== 4'b1110) begin bad++; $display("FAIL edge1_an: D0_AN=%b want 1110", bus.D0_AN); end
    if (bus.frame !== 1'b1) begin bad++; $display("FAIL edge1_frame: frame=%b want 1", bus.frame); end
    if (bus.nib0 !== 4'd0) begin bad++; $display("FAIL edge1_nib: nib0=%h want 0", bus.nib0); end
    tick();
    total += 3;
    if (bus.nib0 !== 4'd4) begin bad++; $display("FAIL edge2_nib: nib0=%h want 4", bus.nib0); end
    if (bus.frame !== 1'b0) begin bad++; $display("FAIL edge2_frame: frame=%b want 0", bus.frame); end
    if (bus.D0_AN !== 4'b1110) begin bad++; $display("FAIL edge2_an: D0_AN=%b want 1110", bus.D0_AN); end
    for (int i = 0; i < 30; i++) begin
      tick();
      pulses += int'(bus.frame === 1'b1);
    end
    total++;
    if (pulses != 0) begin bad++; $display("FAIL startup_pulses: extra frame pulses=%0d want 0", pulses); end
  endtask
  task automatic test_scan;
    logic [15:0] v = 16'h1234;
    sync_frame();
    for (int j = 0; j <= 32; j++) begin
      total += 3;
      if (bus.frame !== (j % 32 == 0)) begin bad++; $display("FAIL scan_frame j=%0d: frame=%b want %b", j, bus.frame, j % 32 == 0); end
      if (bus.nib0 !== v[4*((j/8)%4) +: 4]) begin bad++; $display("FAIL scan_nib j=%0d: nib0=%h want %h", j, bus.nib0, v[4*((j/8)%4) +: 4]); end
      if (bus.D0_AN !== ~(4'd1 << ((j/8)%4))) begin bad++; $display("FAIL scan_an j=%0d: D0_AN=%b want %b", j, bus.D0_AN, ~(4'd1 << ((j/8)%4))); end
      tick();
    end
  endtask
  task automatic test_capture;
    logic [15:0] old_v = 16'hABCD;
    logic [3:0] exp;
    sync_frame();
    for (int j = 0; j < 40; j++) begin
      exp = j < 33 ? old_v[4*((j/8)%4) +: 4] : 4'h8;
      total++;
      if (bus.nib1 !== exp) begin bad++; $display("FAIL capture_nib j=%0d: nib1=%h want %h", j, bus.nib1, exp); end
      if (j == 10) bus.val1 = 16'h5678;
      tick();
    end
  endtask
  task automatic test_lz;
    logic [15:0] vals [3] = '{16'h0050, 16'h0000, 16'h0000};
    logic lzs [3] = '{1'b1, 1'b1, 1'b0};
    logic [3:0] ens [3] = '{4'b0011, 4'b0001, 4'b1111};
    logic [3:0] exp;
    for (int c = 0; c < 3; c++) begin
      bus.val0 = vals[c];
      bus.lz_en = lzs[c];
      sync_frame();
      sync_frame();
      for (int j = 0; j < 32; j++) begin
        exp = ens[c][j/8] ? ~(4'd1 << (j/8)) : 4'hF;
        total += 2;
        if (bus.D0_AN !== exp) begin bad++; $display("FAIL lz_an case=%0d j=%0d: D0_AN=%b want %b", c, j, bus.D0_AN, exp); end
        if (bus.D1_AN !== ~(4'd1 << (j/8))) begin bad++; $display("FAIL lz_an1 case=%0d j=%0d: D1_AN=%b want %b", c, j, bus.D1_AN, ~(4'd1 << (j/8))); end
        tick();
      end
    end
    total++;
    if (bus.nib0 !== 4'h0) begin bad++; $display("FAIL lz_nib: nib0=%h want 0", bus.nib0); end
  endtask
  task automatic test_bright;
    logic [3:0] exp;
    int low;
    bus.lz_en = 1'b0;
    for (int b = 0; b < 3; b++) begin
      bus.bright = 2'(b);
      sync_frame();
      low = 0;
      for (int j = 0; j < 32; j++) begin
        exp = (j % 8) < 2 * (b + 1) ? ~(4'd1 << (j/8)) : 4'hF;
        total++;
        if (bus.D0_AN !== exp) begin bad++; $display("FAIL bright_an b=%0d j=%0d: D0_AN=%b want %b", b, j, bus.D0_AN, exp); end
        low += int'(bus.D0_AN !== 4'hF);
        tick();
      end
      total++;
      if (low != 8 * (b + 1)) begin bad++; $display("FAIL bright_duty b=%0d: on cycles=%0d want %0d", b, low, 8 * (b + 1)); end
    end
    bus.bright = 2'd3;
  endtask
  task automatic test_reset_mid;
    sync_frame();
    repeat (17) tick();
    RST = 1'b1;
    tick();
    total += 5;
    if (bus.D0_AN !== 4'hF) begin bad++; $display("FAIL mid_an0: D0_AN=%b want 1111", bus.D0_AN); end
    if (bus.D1_AN !== 4'hF) begin bad++; $display("FAIL mid_an1: D1_AN=%b want 1111", bus.D1_AN); end
    if (bus.nib0 !== 4'd0) begin bad++; $display("FAIL mid_nib0: nib0=%h want 0", bus.nib0); end
    if (bus.nib1 !== 4'd0) begin bad++; $display("FAIL mid_nib1: nib1=%h want 0", bus.nib1); end
    if (bus.frame !== 1'b0) begin bad++; $display("FAIL mid_frame: frame=%b want 0", bus.frame); end
    tick();
    RST = 1'b0;
    bus.val0 = 16'h4321;
    tick();
    total += 3;
    if (bus.D0_AN !== 4'b1110) begin bad++; $display("FAIL restart_an: D0_AN=%b want 1110", bus.D0_AN); end
    if (bus.frame !== 1'b1) begin bad++; $display("FAIL restart_frame: frame=%b want 1", bus.frame); end
    if (bus.nib0 !== 4'd0) begin bad++; $display("FAIL restart_nib_old: nib0=%h want 0", bus.nib0); end
    tick();
    total += 2;
    if (bus.nib0 !== 4'd1) begin bad++; $display("FAIL restart_nib0: nib0=%h want 1", bus.nib0); end
    if (bus.nib1 !== 4'd8) begin bad++; $display("FAIL restart_nib1: nib1=%h want 8", bus.nib1); end
  endtask
  initial begin
    test_reset();
    test_scan();
    test_capture();
    test_lz();
    test_bright();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
